tiled_matvec_ctrl: RTL and testbench
====================================

# tiled_matvec_ctrl

Sequencer for a GF(2) matrix-vector product. It computes y = A·x over bits, with y[i] = XOR over j of (A[i*W+j] & x[j]), and walks the iteration space in B×B tile order: outer ii, then jj, then i, then j. It evaluates one (i,j) element per cycle against operands captured at start. It owns the loop sequencing, the start/busy control and the result valid/ready handshake for the tiled datapath.

## Interface
Parameters:
- W, 16, matrix dimension and vector width.
- B, 4, tile edge. W % B must be 0 and B ≥ 1; any other value is an elaboration-time error.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, reset; synchronous and active-high.
- start, input, 1, request a new computation; sampled only in IDLE.
- A, input, W*W, matrix, row-major; bit i*W+j is row i, column j. Captured on accepted start.
- x, input, W, vector; captured on accepted start.
- busy, output, 1, high in RUN and HOLD.
- y, output, W, result; valid only while y_valid=1, otherwise 0.
- y_valid, output, 1, result available.
- y_ready, input, 1, consumer accepts result when y_valid & y_ready.

## Operation
- States: IDLE, RUN, HOLD.
- **IDLE**
  - If start=1: latch A→a_q and x→x_q, clear acc (W bits), zero all four indices, go to RUN.
  - Otherwise remain in IDLE.
- **RUN**, each cycle:
  - acc[i] ^= a_q[i*W+j] & x_q[j] for the current (ii, jj, i, j).
  - Then advance the indices in nested-loop order:
    - j increments within [jj, jj+B); on wrap, i increments within [ii, ii+B).
    - On i wrap, jj += B; on jj wrap at W, ii += B.
    - i and j are reset to the new tile origin on every tile change.
  - On the last element (ii=W-B, jj=W-B, i=W-1, j=W-1), go to HOLD instead of advancing.
- **HOLD**
  - y_valid=1 and y=acc, both held stable.
  - On y_valid & y_ready, go to IDLE and drop y_valid next cycle.
- Arithmetic: XOR/AND only. Index registers are $clog2(W) bits, with no overflow beyond W-1; wrap compares use ii+B and jj+B at $clog2(W)+1 bits.
- start outside IDLE is ignored, with no queueing. A and x changing after acceptance has no effect.
- Reset, including mid-RUN or mid-HOLD:
  - State returns to IDLE.
  - busy=0, y_valid=0, y=0; acc, a_q, x_q and indices are cleared.
  - The partial result is discarded.

## Timing
- Start sampled high in IDLE at edge 0. RUN covers edges 1..W*W, one element per edge.
- y_valid rises after edge W*W and is visible in the cycle that follows; default W=16 gives 256 RUN cycles.
- Latency from start sample to y_valid: W*W+1 cycles. Throughput: one result per W*W+2 cycles minimum, because IDLE costs one cycle after the handshake.
- busy rises the cycle after start is accepted and falls the cycle after the y handshake.
- y_ready may be held high in advance; HOLD then lasts exactly one cycle.
- Outputs are registered, with no combinational path from any input to any output.

## Structure
- Package `tiled_pkg`:
  - state enum (IDLE, RUN, HOLD);
  - localparams IW=$clog2(W) and NT=W/B;
  - function `last_elem(ii,jj,i,j)`.
- Sub-module `tile_index_gen`:
  - owns ii/jj/i/j counters;
  - inputs clr and step; outputs the indices and `last`.
- Top holds the FSM, operand registers, accumulator and handshake.

## Test plan
- W=16, B=4, A=identity, x=16'hA5C3, y_ready=1 → y=16'hA5C3 with y_valid first high 257 cycles after start sample, for one cycle; busy high for 257 cycles.
- A=all ones, x=16'h0001 → y=16'hFFFF. A=all ones, x=16'h0003 → y=16'h0000 (even parity).
- Hold y_ready=0 for 20 cycles in HOLD while toggling start and A → y and y_valid stable, and no new run after release until start is reasserted in IDLE.
- Assert rst at cycle 100 of RUN → next cycle busy=0, y_valid=0, y=0. A new start with A=identity, x=16'h00FF gives y=16'h00FF with full latency.
- Index-order check via internal probe, A=identity, x=16'hFFFF → first 5 visited (i,j) are (0,0),(0,1),(0,2),(0,3),(1,0), and the 17th is (0,4).
- W=8, B=2 build, random A and x for 50 runs against a reference model → bit-exact y, latency 65.

Source files
------------

// File: rtl/tiled_pkg.sv
// Shared types and helpers for the tiled GF(2) matrix-vector sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tiled_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   // Width of an index register able to hold 0..w-1 (at least one bit)
   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int W_DEF = 16;
   localparam int B_DEF = 4;
   localparam int IW    = idx_w(W_DEF);
   localparam int NT    = W_DEF / B_DEF;

   // True on the final (ii, jj, i, j) of the tiled walk
   function automatic logic last_elem(input int ii, input int jj, input int i, input int j,
                                      input int w, input int b);
      return (ii == w - b) && (jj == w - b) && (i == w - 1) && (j == w - 1);
   endfunction

endpackage

// File: rtl/tiled_matvec_ctrl_if.sv
// Start/operand request and result valid/ready bundle for the matvec sequencer.
// Latency: n/a (wiring only).
// Backpressure: result held while y_valid & !y_ready.
interface tiled_matvec_ctrl_if #(parameter int W = 16);
   logic           start;
   logic [W*W-1:0] A;
   logic [W-1:0]   x;
   logic           busy;
   logic [W-1:0]   y;
   logic           y_valid;
   logic           y_ready;

   modport master (output start, A, x, y_ready, input busy, y, y_valid);
   modport slave  (input start, A, x, y_ready, output busy, y, y_valid);
endinterface

// File: rtl/tile_index_gen.sv
// Tiled loop counters: outer ii, then jj, then i, then j (tile edge B).
// Latency: indices advance one element per cycle while step is high.
// Backpressure: holds indices whenever step is low; clr returns to origin.
module tile_index_gen
   import tiled_pkg::*;
#(
   parameter int W = 16,
   parameter int B = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                step,
   output logic [idx_w(W)-1:0] ii,
   output logic [idx_w(W)-1:0] jj,
   output logic [idx_w(W)-1:0] i,
   output logic [idx_w(W)-1:0] j,
   output logic                last
);
   localparam int IWL = idx_w(W);
   localparam logic [IWL:0] BE = (IWL+1)'(B);
   localparam logic [IWL:0] WE = (IWL+1)'(W);

   generate
      if ((B < 1) || (W % B != 0)) begin : g_bad_tile
         $error("tile_index_gen: B must be >= 1 and divide W");
      end
   endgenerate

   // Wrap comparisons carried one bit wider so ii+B / jj+B never overflow
   logic [IWL:0] j_nx, i_nx, jj_end, ii_end;
   assign j_nx   = {1'b0, j} + 1'b1;
   assign i_nx   = {1'b0, i} + 1'b1;
   assign jj_end = {1'b0, jj} + BE;
   assign ii_end = {1'b0, ii} + BE;
   assign last   = last_elem(int'(ii), int'(jj), int'(i), int'(j), W, B);

   // Nested-loop advance; i and j snap to the new tile origin on tile change
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ii <= '0;
         jj <= '0;
         i  <= '0;
         j  <= '0;
      end else if (step) begin
         if (j_nx != jj_end) begin
            j <= j_nx[IWL-1:0];
         end else if (i_nx != ii_end) begin
            i <= i_nx[IWL-1:0];
            j <= jj;
         end else if (jj_end != WE) begin
            jj <= jj_end[IWL-1:0];
            i  <= ii;
            j  <= jj_end[IWL-1:0];
         end else begin
            jj <= '0;
            ii <= ii_end[IWL-1:0];
            i  <= ii_end[IWL-1:0];
            j  <= '0;
         end
      end
   end
endmodule

// File: rtl/tiled_matvec_ctrl.sv
// GF(2) y = A.x sequencer, one (i,j) element per cycle in BxB tile order.
// Latency: W*W+1 cycles from start sample to y_valid; W*W+2 cycles per result minimum.
// Backpressure: result held stable in HOLD until y_ready; start ignored while busy.
module tiled_matvec_ctrl
   import tiled_pkg::*;
#(
   parameter int W = 16,
   parameter int B = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   tiled_matvec_ctrl_if.slave   bus
);
   localparam int IWL = idx_w(W);

   state_t               state, state_n;
   logic [W-1:0]         a_rows [W];
   logic [W-1:0]         x_q;
   logic [W-1:0]         acc, acc_n;
   logic [IWL-1:0]       idx_ii, idx_jj, idx_i, idx_j;
   logic                 clr, step, last, prod;

   tile_index_gen #(.W(W), .B(B)) u_idx (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .step (step),
      .ii   (idx_ii),
      .jj   (idx_jj),
      .i    (idx_i),
      .j    (idx_j),
      .last (last)
   );

   // Next-state and loop control: accept start in IDLE, finish on last element
   always_comb begin
      state_n = state;
      clr     = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            state_n = RUN;
            clr     = 1'b1;
         end
         RUN: if (last) state_n = HOLD;
              else      step    = 1'b1;
         HOLD: if (bus.y_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // One partial product folded into accumulator bit i
   always_comb begin
      prod         = a_rows[idx_i][idx_j] & x_q[idx_j];
      acc_n        = acc;
      acc_n[idx_i] = acc[idx_i] ^ prod;
   end

   // State, operand capture and accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x_q   <= '0;
         acc   <= '0;
         for (int r = 0; r < W; r++) a_rows[r] <= '0;
      end else begin
         state <= state_n;
         if (clr) begin
            for (int r = 0; r < W; r++) a_rows[r] <= bus.A[r*W +: W];
            x_q <= bus.x;
            acc <= '0;
         end else if (state == RUN) begin
            acc <= acc_n;
         end
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.y_valid = (state == HOLD);
   assign bus.y       = (state == HOLD) ? acc : '0;
endmodule

// File: tb/tb_tiled_matvec_ctrl.sv
// Bench for tiled_matvec_ctrl: W=16/B=4 and W=8/B=2 instances against a spec-level model.
// Latency: n/a.
// Backpressure: exercises held y_ready and start toggling while busy.
module tb_tiled_matvec_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tiled_matvec_ctrl_if #(.W(16)) bus16();
   tiled_matvec_ctrl_if #(.W(8))  bus8();

   tiled_matvec_ctrl #(.W(16), .B(4)) u_d16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   tiled_matvec_ctrl #(.W(8),  .B(2)) u_d8  (.clk(clk), .rst(rst), .bus(bus8.slave));

   logic         st [2];
   logic [255:0] av [2];
   logic [15:0]  xv [2];
   logic         rd [2];

   assign bus16.start   = st[0];
   assign bus16.A       = av[0];
   assign bus16.x       = xv[0];
   assign bus16.y_ready = rd[0];
   assign bus8.start    = st[1];
   assign bus8.A        = av[1][63:0];
   assign bus8.x        = xv[1][7:0];
   assign bus8.y_ready  = rd[1];

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   int mw [2]   = '{16, 8};

   function automatic logic o_busy(input int k);
      return (k == 0) ? bus16.busy : bus8.busy;
   endfunction
   function automatic logic o_valid(input int k);
      return (k == 0) ? bus16.y_valid : bus8.y_valid;
   endfunction
   function automatic logic [15:0] o_y(input int k);
      return (k == 0) ? bus16.y : {8'h00, bus8.y};
   endfunction

   // Reference: y[i] = parity of (row i of A) AND x
   function automatic logic [15:0] ref_mv(input logic [255:0] a, input logic [15:0] xx, input int w);
      logic [15:0] r = '0;
      for (int i = 0; i < w; i++)
         for (int j = 0; j < w; j++)
            r[i] = r[i] ^ (a[i*w+j] & xx[j]);
      return r;
   endfunction

   function automatic logic [255:0] ident(input int w);
      logic [255:0] a = '0;
      for (int i = 0; i < w; i++) a[i*w+i] = 1'b1;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Spec-level model: idle, W*W run cycles, then hold until y_ready
   int          m_ph  [2] = '{0, 0};
   int          m_cnt [2] = '{0, 0};
   logic [15:0] m_y   [2] = '{16'h0, 16'h0};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_ph[k] = 0;
         end else if (m_ph[k] == 0) begin
            if (st[k]) begin
               m_ph[k]  = 1;
               m_cnt[k] = mw[k] * mw[k];
               m_y[k]   = ref_mv(av[k], xv[k], mw[k]);
            end
         end else if (m_ph[k] == 1) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) m_ph[k] = 2;
         end else if (rd[k]) begin
            m_ph[k] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_busy%0d", k),  {31'b0, o_busy(k)},  {31'b0, m_ph[k] != 0});
            chk($sformatf("model_valid%0d", k), {31'b0, o_valid(k)}, {31'b0, m_ph[k] == 2});
            chk($sformatf("model_y%0d", k),     {16'b0, o_y(k)},     {16'b0, (m_ph[k] == 2) ? m_y[k] : 16'h0});
         end
      end
   end

   logic [7:0] pq [$];

   // Issue one start and observe until result handshake (or first valid if rdy=0)
   task automatic run(input int k, input logic [255:0] a, input logic [15:0] xx, input logic rdy,
                      input bit probe, output logic [15:0] yo, output int lat, output int bc);
      bit seen = 1'b0;
      av[k] = a; xv[k] = xx; rd[k] = rdy; st[k] = 1'b1;
      lat = -1; bc = 0; yo = '0;
      @(posedge clk); #1 st[k] = 1'b0;
      for (int n = 1; n < 2000; n++) begin
         @(negedge clk);
         if (o_busy(k)) bc++;
         if (probe && n <= 17) pq.push_back({u_d16.u_idx.i, u_d16.u_idx.j});
         if (o_valid(k) && !seen) begin
            seen = 1'b1;
            lat  = n;
            yo   = o_y(k);
            if (!rdy) break;
         end
         if (seen && !o_busy(k)) break;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL timeout k=%0d actual=no_y_valid required=y_valid", k);
      end
   endtask

   logic [255:0] ones;
   logic [15:0]  yr, ye;
   int           lat, bc;

   initial begin
      ones = '1;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         st[k] = 1'b0; av[k] = '0; xv[k] = '0; rd[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy",  {31'b0, bus16.busy},    32'd0);
      chk("rst_valid", {31'b0, bus16.y_valid}, 32'd0);
      chk("rst_y",     {16'b0, bus16.y},       32'd0);

      // Pin the reference model itself
      chk("ref_ident", {16'b0, ref_mv(ident(16), 16'hA5C3, 16)}, 32'h0000A5C3);
      chk("ref_ones1", {16'b0, ref_mv(ones, 16'h0001, 16)},      32'h0000FFFF);
      chk("ref_ones3", {16'b0, ref_mv(ones, 16'h0003, 16)},      32'h00000000);

      // Identity pass-through, latency, busy span and visit order
      run(0, ident(16), 16'hA5C3, 1'b1, 1'b1, yr, lat, bc);
      chk("ident_y",    {16'b0, yr}, 32'h0000A5C3);
      chk("ident_lat",  lat, 32'd257);
      chk("ident_busy", bc,  32'd257);
      chk("order0",  {24'b0, pq[0]},  32'h00);
      chk("order1",  {24'b0, pq[1]},  32'h01);
      chk("order2",  {24'b0, pq[2]},  32'h02);
      chk("order3",  {24'b0, pq[3]},  32'h03);
      chk("order4",  {24'b0, pq[4]},  32'h10);
      chk("order16", {24'b0, pq[16]}, 32'h04);

      // Parity cases
      run(0, ones, 16'h0001, 1'b1, 1'b0, yr, lat, bc);
      chk("ones1_y", {16'b0, yr}, 32'h0000FFFF);
      run(0, ones, 16'h0003, 1'b1, 1'b0, yr, lat, bc);
      chk("ones3_y", {16'b0, yr}, 32'h00000000);
      chk("ones3_lat", lat, 32'd257);

      // Held result under backpressure while start and A are disturbed
      run(0, ident(16), 16'h1234, 1'b0, 1'b0, yr, lat, bc);
      chk("hold_y0", {16'b0, yr}, 32'h00001234);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         st[0] = ~st[0];
         av[0] = {8{$urandom()}};
         @(negedge clk);
         chk("hold_valid", {31'b0, bus16.y_valid}, 32'd1);
         chk("hold_y",     {16'b0, bus16.y},       32'h00001234);
      end
      st[0] = 1'b0;
      rd[0] = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("release_idle", {31'b0, bus16.busy}, 32'd0);
      end

      // Reset in the middle of RUN discards the partial result
      av[0] = ones; xv[0] = 16'hBEEF; st[0] = 1'b1;
      @(posedge clk); #1 st[0] = 1'b0;
      repeat (99) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy",  {31'b0, bus16.busy},    32'd0);
      chk("midrst_valid", {31'b0, bus16.y_valid}, 32'd0);
      chk("midrst_y",     {16'b0, bus16.y},       32'd0);
      run(0, ident(16), 16'h00FF, 1'b1, 1'b0, yr, lat, bc);
      chk("postrst_y",   {16'b0, yr}, 32'h000000FF);
      chk("postrst_lat", lat, 32'd257);

      // Small build, random operands
      for (int r = 0; r < 50; r++) begin
         logic [255:0] a8;
         logic [15:0]  x8;
         a8 = '0;
         a8[63:0] = {$urandom(), $urandom()};
         x8 = 16'($urandom_range(0, 255));
         ye = ref_mv(a8, x8, 8);
         run(1, a8, x8, 1'b1, 1'b0, yr, lat, bc);
         chk("w8_y",   {16'b0, yr}, {16'b0, ye});
         chk("w8_lat", lat, 32'd65);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
